spi_byte_queue: RTL and testbench

- Byte-stream front end that sits directly upstream of the SPI master.
- Buffers bytes from the host in a TX FIFO and launches one SPI transfer per byte through a start/busy handshake with the master.
- Captures each received byte into an RX FIFO for the host to read.
- Decouples host bursts from the serial rate and reports start timeouts and RX overflow.

---
 rtl/spi_byte_queue_if.sv | 35 +++
 rtl/spi_byte_queue.sv | 131 +++++++++++++
 tb/tb_spi_byte_queue.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_byte_queue_if.sv
// Host and SPI-master signal bundle for spi_byte_queue.
//   slave  : view taken by spi_byte_queue (drives status, M_START/M_DOUT)
//   master : view taken by the host/master side (drives pushes, pops, M_BUSY/M_DIN)
// AW sizes the level outputs (AW+1 bits) and must match the queue's AW.
`timescale 1ns/1ps
interface spi_byte_queue_if #(parameter int AW = 3);
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          tx_full;
  logic [AW:0]   tx_level;
  logic          rd_en;
  logic [7:0]    rd_data;
  logic          rx_empty;
  logic [AW:0]   rx_level;
  logic          rx_ovf;
  logic          start_err;
  logic          clr_err;
  logic          idle;
  logic          m_start;
  logic [7:0]    m_dout;
  logic          m_busy;
  logic [7:0]    m_din;

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err, m_busy, m_din,
    output tx_full, tx_level, rd_data, rx_empty, rx_level,
           rx_ovf, start_err, idle, m_start, m_dout
  );

  modport master (
    output wr_en, wr_data, rd_en, clr_err, m_busy, m_din,
    input  tx_full, tx_level, rd_data, rx_empty, rx_level,
           rx_ovf, start_err, idle, m_start, m_dout
  );
endinterface

// File: rtl/spi_byte_queue.sv
// Byte-stream front end for an SPI master.
// Host bytes are queued in a TX FIFO; each is handed to the master with a
// one-cycle m_start and a start/busy handshake. The byte returned by the
// master is captured into an RX FIFO (first-word fall-through on rd_data).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : spi_byte_queue_if.slave
//     host side   wr_en/wr_data/tx_full/tx_level, rd_en/rd_data/rx_empty/rx_level
//     status      rx_ovf, start_err (sticky, cleared by clr_err), idle
//     master side m_start/m_dout out, m_busy/m_din in
`timescale 1ns/1ps
module spi_byte_queue #(
  parameter int DEPTH         = 8,
  parameter int AW            = $clog2(DEPTH),
  parameter int START_TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_byte_queue_if.slave bus
);
  localparam int          TW   = $clog2(START_TIMEOUT + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_CAPT} state_t;
  state_t state_q, state_d;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wp, tx_rp;
  logic [AW:0]   tx_cnt;
  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp;
  logic [AW:0]   rx_cnt;

  logic [TW-1:0] to_cnt;
  logic [7:0]    dout_q, din_q;
  logic          start_q, ovf_q, err_q;

  logic tx_push, tx_pop, rx_push, rx_pop, set_ovf, set_err;

  assign tx_push = bus.wr_en && (tx_cnt != FULL);
  assign rx_pop  = bus.rd_en && (rx_cnt != '0);

  always_comb begin
    state_d = state_q;
    tx_pop  = 1'b0;
    rx_push = 1'b0;
    set_ovf = 1'b0;
    set_err = 1'b0;
    case (state_q)
      S_IDLE: if (tx_cnt != '0 && !bus.m_busy) begin
        tx_pop  = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.m_busy) state_d = S_XFER;
        else if (to_cnt == TW'(START_TIMEOUT - 1)) begin
          set_err = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_XFER: if (!bus.m_busy) state_d = S_CAPT;
      S_CAPT: begin
        // Host pop in this cycle frees a slot before the capture lands.
        if (rx_cnt != FULL || rx_pop) rx_push = 1'b1;
        else                          set_ovf = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;

  // FIFO storage carries no reset; rd_data is gated by the empty flag.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.wr_data;
    if (rx_push) rx_mem[rx_wp] <= din_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
      dout_q  <= '0;
      din_q   <= '0;
      to_cnt  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= tx_pop;
      if (tx_pop) dout_q <= tx_mem[tx_rp];
      if (tx_pop)                                 to_cnt <= '0;
      else if (state_q == S_WAIT && !bus.m_busy) to_cnt <= to_cnt + TW'(1);
      // Sample the returned byte on the cycle busy is seen low.
      if (state_q == S_XFER && !bus.m_busy) din_q <= bus.m_din;
      // Set beats a simultaneous clear.
      ovf_q <= set_ovf | (ovf_q & ~bus.clr_err);
      err_q <= set_err | (err_q & ~bus.clr_err);
    end
  end

  assign bus.tx_full   = (tx_cnt == FULL);
  assign bus.tx_level  = tx_cnt;
  assign bus.rx_empty  = (rx_cnt == '0);
  assign bus.rx_level  = rx_cnt;
  assign bus.rd_data   = (rx_cnt == '0) ? 8'h00 : rx_mem[rx_rp];
  assign bus.rx_ovf    = ovf_q;
  assign bus.start_err = err_q;
  assign bus.idle      = (state_q == S_IDLE) && (tx_cnt == '0);
  assign bus.m_start   = start_q;
  assign bus.m_dout    = dout_q;
endmodule

// File: tb/tb_spi_byte_queue.sv
`timescale 1ns/1ps
module tb_spi_byte_queue;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int TO    = 15;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_byte_queue_if #(.AW(AW)) bus ();
  spi_byte_queue #(.DEPTH(DEPTH), .AW(AW), .START_TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic busy_m = 1'b0, hold_busy = 1'b0;
  logic rd_host = 1'b0, rd_cap = 1'b0;
  assign bus.m_busy = busy_m | hold_busy;
  assign bus.rd_en  = rd_host | rd_cap;

  int total = 0, bad = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rx[$];
  int   tx_out = 0;
  int   n_start = 0;
  logic exp_ovf = 1'b0, exp_err = 1'b0;

  // master-model knobs
  logic rnd = 1'b0, never_busy = 1'b0, long_busy = 1'b0, rd_in_capt = 1'b0;
  logic fixed_din = 1'b0, abort = 1'b0, m_active = 1'b0;
  logic [7:0] din_val = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_tx_level"},  bus.tx_level, 0);
    chk({tag, "_tx_full"},   bus.tx_full, 0);
    chk({tag, "_rx_empty"},  bus.rx_empty, 1);
    chk({tag, "_rx_level"},  bus.rx_level, 0);
    chk({tag, "_rd_data"},   bus.rd_data, 0);
    chk({tag, "_m_start"},   bus.m_start, 0);
    chk({tag, "_m_dout"},    bus.m_dout, 0);
    chk({tag, "_rx_ovf"},    bus.rx_ovf, 0);
    chk({tag, "_start_err"}, bus.start_err, 0);
    chk({tag, "_idle"},      bus.idle, 1);
  endtask

  // Call at posedge+1; returns at the following posedge+1.
  task automatic push(input logic [7:0] b);
    bus.wr_en = 1'b1;
    bus.wr_data = b;
    if (tx_out < DEPTH) begin
      exp_tx.push_back(b);
      tx_out++;
    end
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_quiet();
    int n = 0;
    while ((exp_tx.size() != 0 || m_active) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL quiet_timeout: got %0d pending want 0", exp_tx.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic drain();
    int n = exp_rx.size();
    @(posedge clk); #1;
    if (n != 0) begin
      rd_host = 1'b1;
      repeat (n) @(posedge clk);
      #1 rd_host = 1'b0;
    end
    @(negedge clk);
    chk("drain_rx_level", bus.rx_level, 0);
    chk("drain_rd_data", bus.rd_data, 0);
  endtask

  task automatic clr();
    @(posedge clk); #1 bus.clr_err = 1'b1;
    @(posedge clk); #1 bus.clr_err = 1'b0;
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    @(negedge clk);
    chk("clr_ovf", bus.rx_ovf, 0);
    chk("clr_err", bus.start_err, 0);
  endtask

  // RX monitor: every host pop must present the oldest expected byte.
  always @(negedge clk)
    if (rst_n && bus.rd_en && exp_rx.size() > 0)
      chk("rx_data", bus.rd_data, exp_rx.pop_front());

  // SPI master model + TX monitor.
  initial begin : master
    logic [7:0] got, din;
    int dly, len;
    bus.m_din = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.m_start) begin
        n_start++;
        got = bus.m_dout;
        if (exp_tx.size() == 0) begin
          total++; bad++;
          $display("FAIL spurious_start: got %0h want none", got);
        end else begin
          chk("tx_order", got, exp_tx.pop_front());
          tx_out--;
        end
        m_active = 1'b1;
        @(negedge clk);
        chk("start_pulse", bus.m_start, 0);
        if (never_busy) begin
          repeat (TO - 2) @(negedge clk);
          chk("err_before_to", bus.start_err, exp_err);
          @(negedge clk);
          chk("err_at_to", bus.start_err, 1);
          exp_err = 1'b1;
        end else begin
          dly = rnd ? int'($urandom_range(2, 4)) : 2;
          len = long_busy ? 40 : (rnd ? int'($urandom_range(1, 6)) : 10);
          din = fixed_din ? din_val : 8'($urandom);
          for (int i = 0; i < dly - 1 && !abort; i++) @(posedge clk);
          #1;
          if (!abort) begin
            busy_m = 1'b1;
            for (int i = 0; i < len && !abort; i++) @(posedge clk);
            #1;
          end
          if (!abort) begin
            chk("dout_hold", bus.m_dout, got);
            bus.m_din = din;
            busy_m = 1'b0;
            @(posedge clk);
            if (rd_in_capt) #1 rd_cap = 1'b1;
            @(posedge clk);
            #1 rd_cap = 1'b0;
            if (exp_rx.size() < DEPTH) exp_rx.push_back(din);
            else                       exp_ovf = 1'b1;
          end else begin
            busy_m = 1'b0;
          end
        end
        m_active = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, n;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.clr_err = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_rst("reset");
    rst_n = 1'b1;

    // single byte: latency, loopback, idle afterwards
    fixed_din = 1'b1;
    din_val = 8'h3C;
    @(posedge clk); #1;
    push(8'hA5);
    @(negedge clk);
    chk("lat_k_start", bus.m_start, 0);
    chk("lat_k_level", bus.tx_level, 1);
    @(negedge clk);
    chk("lat_k1_start", bus.m_start, 1);
    chk("lat_k1_dout", bus.m_dout, 8'hA5);
    wait_quiet();
    chk("t1_rd_data", bus.rd_data, 8'h3C);
    chk("t1_rx_level", bus.rx_level, 1);
    chk("t1_idle", bus.idle, 1);
    chk("t1_nstart", n_start, 1);
    drain();
    fixed_din = 1'b0;

    // randomized traffic with concurrent host reads
    rnd = 1'b1;
    fork
      begin
        @(posedge clk); #1;
        for (int i = 0; i < 24; i++) begin
          n = 0;
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          while (tx_out >= DEPTH && n < 500) begin @(posedge clk); #1; n++; end
          push(8'($urandom));
        end
      end
      begin
        repeat (400) begin
          @(posedge clk); #1 rd_host = ($urandom_range(0, 2) == 0);
        end
        rd_host = 1'b0;
      end
    join
    wait_quiet();
    chk("rnd_idle", bus.idle, 1);
    chk("rnd_tx_level", bus.tx_level, 0);
    chk("rnd_rx_level", bus.rx_level, exp_rx.size());
    chk("rnd_ovf", bus.rx_ovf, exp_ovf);
    drain();
    clr();
    rnd = 1'b0;

    // start timeout: master never goes busy
    never_busy = 1'b1;
    @(posedge clk); #1;
    push(8'h11);
    push(8'h22);
    wait_quiet();
    chk("to_err", bus.start_err, exp_err);
    chk("to_idle", bus.idle, 1);
    never_busy = 1'b0;
    clr();

    // DEPTH+1 pushes while the master holds busy
    hold_busy = 1'b1;
    @(posedge clk); #1;
    for (int b = 1; b <= DEPTH + 1; b++) push(8'(b));
    @(negedge clk);
    chk("full_flag", bus.tx_full, 1);
    chk("full_level", bus.tx_level, DEPTH);
    chk("full_model", exp_tx.size(), DEPTH);
    @(posedge clk); #1 hold_busy = 1'b0;
    wait_quiet();
    chk("fill_rx_level", bus.rx_level, DEPTH);
    chk("fill_tx_full", bus.tx_full, 0);
    chk("fill_ovf", bus.rx_ovf, 0);

    // RX overflow, then full RX popped in the capture cycle
    @(posedge clk); #1;
    push(8'h77);
    wait_quiet();
    chk("ovf_flag", bus.rx_ovf, exp_ovf);
    chk("ovf_set", exp_ovf, 1);
    chk("ovf_level", bus.rx_level, DEPTH);
    clr();
    rd_in_capt = 1'b1;
    @(posedge clk); #1;
    push(8'h88);
    wait_quiet();
    rd_in_capt = 1'b0;
    chk("capt_rd_ovf", bus.rx_ovf, 0);
    chk("capt_rd_level", bus.rx_level, DEPTH);
    drain();

    // asynchronous reset in the middle of a transfer
    long_busy = 1'b1;
    @(posedge clk); #1;
    for (int b = 0; b < 4; b++) push(8'hC0 + 8'(b));
    n = 0;
    while (!busy_m && n < 50) begin @(posedge clk); n++; end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL xfer_wait: got idle master want busy");
    end
    @(negedge clk);
    chk("pre_rst_level", bus.tx_level, 3);
    #2 rst_n = 1'b0;
    abort = 1'b1;
    #1 chk_rst("midrst");
    n = 0;
    while (m_active && n < 100) begin @(posedge clk); n++; end
    exp_tx.delete();
    exp_rx.delete();
    tx_out = 0;
    exp_ovf = 1'b0;
    exp_err = 1'b0;
    abort = 1'b0;
    long_busy = 1'b0;
    s0 = n_start;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("post_rst_nstart", n_start, s0);
    chk("post_rst_idle", bus.idle, 1);
    chk("post_rst_level", bus.tx_level, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
